// File: rtl/dsp_cfg_pkg.sv
// Shared configuration-chain layout for the DSP input register blocks.
// Field offsets depend on the stage-index width, so they are exposed as functions.
package dsp_cfg_pkg;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CFG_A_INPUT   = 0;
  localparam int CFG_AMULTSEL  = 1;
  localparam int CFG_REG_COUNT = 2;

  function automatic int cfg_casc_tap(input int sw);
    return 2 + sw;
  endfunction

  function automatic int cfg_rst_inv(input int sw);
    return 2 + 2 * sw;
  endfunction

  function automatic int chain_len(input int sw);
    return 3 + 2 * sw;
  endfunction

endpackage

// File: rtl/multi_stage_input_register_block_if.sv
// Data/control bundle of the multi-stage A input register block.
interface multi_stage_input_register_block_if #(
  parameter int DATA_W = 30,
  parameter int MULT_W = 27,
  parameter int DEPTH  = 4,
  parameter int SEL_W  = $clog2(DEPTH + 1)
);
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] ACIN;
  logic [MULT_W-1:0] AD_DATA;
  logic [DEPTH-1:0]  CE;
  logic              RST_DATA;
  logic [SEL_W-1:0]  MULT_TAP;
  logic              INMODE_EN;
  logic [DATA_W-1:0] ACOUT;
  logic [DATA_W-1:0] X_MUX;
  logic [MULT_W-1:0] A_MULT;
  logic [MULT_W-1:0] A2A1;
  logic              PIPE_VALID;

  modport master (
    output A, ACIN, AD_DATA, CE, RST_DATA, MULT_TAP, INMODE_EN,
    input  ACOUT, X_MUX, A_MULT, A2A1, PIPE_VALID
  );

  modport slave (
    input  A, ACIN, AD_DATA, CE, RST_DATA, MULT_TAP, INMODE_EN,
    output ACOUT, X_MUX, A_MULT, A2A1, PIPE_VALID
  );
endinterface

// File: rtl/input_reg_stage.sv
// One A-path register stage: data word with CE and sync clear, plus its fill-valid bit.
module input_reg_stage #(
  parameter int DATA_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              ce_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic              v_i,
  input  logic              v_clr_i,
  output logic [DATA_W-1:0] q_o,
  output logic              v_o
);
  logic [DATA_W-1:0] q_q, q_d;
  logic              v_q, v_d;

  always_comb begin
    q_d = q_q;
    v_d = v_q;
    if (clr_i) begin
      q_d = '0;
    end else if (ce_i) begin
      q_d = d_i;
    end
    if (v_clr_i) begin
      v_d = 1'b0;
    end else if (ce_i) begin
      v_d = v_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
      v_q <= 1'b0;
    end else begin
      q_q <= q_d;
      v_q <= v_d;
    end
  end

  assign q_o = q_q;
  assign v_o = v_q;
endmodule

// File: rtl/multi_stage_input_register_block.sv
// DEPTH-deep A input register chain with serial configuration, cascade/multiplier taps
// and a pipeline-fill valid flag.
module multi_stage_input_register_block
  import dsp_cfg_pkg::*;
#(
  parameter int DATA_W        = 30,
  parameter int MULT_W        = 27,
  parameter int DEPTH         = 4,
  parameter int SEL_W         = sel_w(DEPTH),
  parameter bit input_freezed = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst,
  multi_stage_input_register_block_if.slave  bus,
  input  logic                               configuration_input,
  input  logic                               configuration_enable,
  output logic                               configuration_output
);
  localparam int CHAIN_W  = chain_len(SEL_W);
  localparam int CASC_LSB = cfg_casc_tap(SEL_W);
  localparam int RINV_BIT = cfg_rst_inv(SEL_W);
  localparam logic [SEL_W-1:0] DEPTH_SEL = SEL_W'(DEPTH);

  logic [CHAIN_W-1:0] cfg_q, cfg_d;
  logic               a_input, amultsel, rst_inv, rdat;
  logic [SEL_W-1:0]   reg_count, casc_tap, n_eff;
  logic [DATA_W-1:0]  s [DEPTH+1];
  logic [DEPTH:0]     v;
  logic [DATA_W-1:0]  x_mux, acout, tap;
  logic [MULT_W-1:0]  a2a1;
  logic               pipe_valid;
  logic               tap_unused;

  always_comb begin
    cfg_d = cfg_q;
    if (configuration_enable) cfg_d = {cfg_q[CHAIN_W-2:0], configuration_input};
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_q <= '0;
    else     cfg_q <= cfg_d;
  end

  assign a_input              = cfg_q[CFG_A_INPUT];
  assign amultsel             = cfg_q[CFG_AMULTSEL];
  assign reg_count            = cfg_q[CFG_REG_COUNT +: SEL_W];
  assign casc_tap             = cfg_q[CASC_LSB +: SEL_W];
  assign rst_inv              = cfg_q[RINV_BIT];
  assign configuration_output = rst_inv;

  always_comb begin
    n_eff = reg_count;
    if (input_freezed || (reg_count > DEPTH_SEL)) n_eff = DEPTH_SEL;
  end

  assign rdat = bus.RST_DATA ^ rst_inv;
  assign s[0] = a_input ? bus.ACIN : bus.A;
  assign v[0] = 1'b1;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    input_reg_stage #(.DATA_W(DATA_W)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (rdat),
      .ce_i    (bus.CE[k-1]),
      .d_i     (s[k-1]),
      .v_i     (v[k-1]),
      .v_clr_i (rdat | configuration_enable),
      .q_o     (s[k]),
      .v_o     (v[k])
    );
  end

  // Taps beyond the effective depth fall back to the pipeline output.
  always_comb begin
    x_mux      = s[0];
    pipe_valid = v[0];
    for (int k = 0; k <= DEPTH; k++) begin
      if (SEL_W'(k) == n_eff) begin
        x_mux      = s[k];
        pipe_valid = v[k];
      end
    end
    acout = x_mux;
    tap   = x_mux;
    for (int k = 0; k <= DEPTH; k++) begin
      if ((SEL_W'(k) == casc_tap) && (casc_tap <= n_eff))     acout = s[k];
      if ((SEL_W'(k) == bus.MULT_TAP) && (bus.MULT_TAP <= n_eff)) tap = s[k];
    end
  end

  assign a2a1       = tap[MULT_W-1:0] & {MULT_W{bus.INMODE_EN}};
  assign tap_unused = ^tap;

  assign bus.X_MUX      = x_mux;
  assign bus.ACOUT      = acout;
  assign bus.A2A1       = a2a1;
  assign bus.A_MULT     = amultsel ? bus.AD_DATA : a2a1;
  assign bus.PIPE_VALID = pipe_valid;
endmodule

// File: tb/tb_multi_stage_input_register_block.sv
// Directed and randomized checks of the multi-stage A input register block.
module tb_multi_stage_input_register_block;
  localparam int DW = 30, MW = 27, DEPTH = 4, SW = 3, CH = 3 + 2 * SW;

  logic clk = 1'b0;
  logic rst, cfg_in, cfg_en, cfg_out;
  int   tests = 0, fails = 0;

  always #5 clk = ~clk;

  multi_stage_input_register_block_if #(.DATA_W(DW), .MULT_W(MW), .DEPTH(DEPTH), .SEL_W(SW)) bus ();

  multi_stage_input_register_block #(.DATA_W(DW), .MULT_W(MW), .DEPTH(DEPTH), .SEL_W(SW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .bus                  (bus),
    .configuration_input  (cfg_in),
    .configuration_enable (cfg_en),
    .configuration_output (cfg_out)
  );

  // Reference model: config bits by position, stage contents and fill flags as arrays.
  logic [CH-1:0] m_cfg;
  logic [DW-1:0] m_st [1:DEPTH];
  logic          m_v  [1:DEPTH];

  function automatic int m_n();
    int rc = int'(m_cfg[2 +: SW]);
    return (rc > DEPTH) ? DEPTH : rc;
  endfunction

  function automatic logic [DW-1:0] m_s(int k);
    if (k == 0) return m_cfg[0] ? bus.ACIN : bus.A;
    return m_st[k];
  endfunction

  function automatic logic [DW-1:0] m_x();
    return m_s(m_n());
  endfunction

  function automatic logic [DW-1:0] m_acout();
    int c = int'(m_cfg[2 + SW +: SW]);
    return (c <= m_n()) ? m_s(c) : m_x();
  endfunction

  function automatic logic [MW-1:0] m_a2a1();
    int t = int'(bus.MULT_TAP);
    logic [DW-1:0] w = (t <= m_n()) ? m_s(t) : m_x();
    return bus.INMODE_EN ? w[MW-1:0] : '0;
  endfunction

  function automatic logic m_pv();
    int n = m_n();
    return (n == 0) ? 1'b1 : m_v[n];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("X_MUX", 32'(bus.X_MUX), 32'(m_x()));
    chk("ACOUT", 32'(bus.ACOUT), 32'(m_acout()));
    chk("A2A1", 32'(bus.A2A1), 32'(m_a2a1()));
    chk("A_MULT", 32'(bus.A_MULT), 32'(m_cfg[1] ? bus.AD_DATA : m_a2a1()));
    chk("PIPE_VALID", 32'(bus.PIPE_VALID), 32'(m_pv()));
    chk("CFG_OUT", 32'(cfg_out), 32'(m_cfg[CH-1]));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    logic [DW-1:0] s_old [0:DEPTH];
    logic          v_old [0:DEPTH];
    logic          rdat;
    for (int k = 0; k <= DEPTH; k++) s_old[k] = m_s(k);
    v_old[0] = 1'b1;
    for (int k = 1; k <= DEPTH; k++) v_old[k] = m_v[k];
    if (rst) begin
      m_cfg = '0;
      for (int k = 1; k <= DEPTH; k++) begin
        m_st[k] = '0;
        m_v[k]  = 1'b0;
      end
    end else begin
      rdat = bus.RST_DATA ^ m_cfg[CH-1];
      for (int k = 1; k <= DEPTH; k++) begin
        if (rdat) m_st[k] = '0;
        else if (bus.CE[k-1]) m_st[k] = s_old[k-1];
        if (rdat || cfg_en) m_v[k] = 1'b0;
        else if (bus.CE[k-1]) m_v[k] = v_old[k-1];
      end
      if (cfg_en) m_cfg = {m_cfg[CH-2:0], cfg_in};
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic settle();
    #1;
    chk_all();
  endtask

  task automatic load_cfg(input logic ai, input logic ams, input logic [SW-1:0] rc,
                          input logic [SW-1:0] ct, input logic ri);
    logic [CH-1:0] b = {ri, ct, rc, ams, ai};
    cfg_en = 1'b1;
    for (int i = CH - 1; i >= 0; i--) begin
      cfg_in = b[i];
      step();
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  logic [0:CH-1] pat;

  initial begin
    m_cfg = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      m_st[k] = '0;
      m_v[k]  = 1'b0;
    end
    rst = 1'b1; cfg_en = 1'b1; cfg_in = 1'b1;
    bus.A = '0; bus.ACIN = '0; bus.AD_DATA = '0; bus.CE = '1;
    bus.RST_DATA = 1'b0; bus.MULT_TAP = '0; bus.INMODE_EN = 1'b0;
    step(); step();
    rst = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0;
    step();
    chk("rst_xmux", 32'(bus.X_MUX), 32'h0);
    chk("rst_pipe_valid", 32'(bus.PIPE_VALID), 32'h1);
    chk("rst_cfg_out", 32'(cfg_out), 32'h0);
    chk("rst_amult", 32'(bus.A_MULT), 32'h0);

    // Shift a pattern in, then replay it out in order.
    pat = 9'b101100100;
    cfg_en = 1'b1;
    for (int i = 0; i < CH; i++) begin
      cfg_in = pat[i];
      step();
    end
    cfg_in = 1'b0;
    for (int j = 0; j < CH; j++) begin
      chk("cfg_replay", 32'(cfg_out), 32'(pat[j]));
      step();
    end
    cfg_en = 1'b0;

    // Latency with REG_COUNT=3, CASC_TAP=1.
    load_cfg(1'b0, 1'b0, 3'd3, 3'd1, 1'b0);
    bus.CE = 4'b1111;
    bus.A = 30'h1; step();
    chk("lat_acout_c1", 32'(bus.ACOUT), 32'h1);
    bus.A = 30'h2; step();
    chk("lat_pv_c2", 32'(bus.PIPE_VALID), 32'h0);
    bus.A = 30'h0; step();
    chk("lat_x_c3", 32'(bus.X_MUX), 32'h1);
    chk("lat_pv_c3", 32'(bus.PIPE_VALID), 32'h1);
    step();
    chk("lat_x_c4", 32'(bus.X_MUX), 32'h2);

    // Multiplier tap and gate.
    bus.MULT_TAP = 3'd2; bus.INMODE_EN = 1'b0; bus.A = 30'h2ABC_DEF0;
    step(); step();
    settle();
    chk("a2a1_gated", 32'(bus.A2A1), 32'h0);
    bus.INMODE_EN = 1'b1; settle();
    chk("a2a1_tap2", 32'(bus.A2A1), 32'h2BC_DEF0);
    bus.MULT_TAP = 3'd5; settle();
    chk("a2a1_tap_beyond_n", 32'(bus.A2A1), 32'h0);

    // Stall of stage 2 while stage 3 keeps loading.
    bus.MULT_TAP = 3'd2; bus.CE = 4'b1111;
    bus.A = 30'd10; step();
    bus.A = 30'd20; step();
    bus.A = 30'd30; step();
    bus.CE = 4'b1101; bus.A = 30'd40; step();
    chk("stall_s3", 32'(bus.X_MUX), 32'd20);
    chk("stall_s2", 32'(bus.A2A1), 32'd20);
    chk("stall_s1", 32'(bus.ACOUT), 32'd40);
    bus.CE = 4'b1111;

    // Reconfiguration drops valid; it refills after N loads.
    load_cfg(1'b0, 1'b0, 3'd3, 3'd1, 1'b0);
    chk("recfg_pv0", 32'(bus.PIPE_VALID), 32'h0);
    step(); step();
    chk("recfg_pv2", 32'(bus.PIPE_VALID), 32'h0);
    step();
    chk("recfg_pv3", 32'(bus.PIPE_VALID), 32'h1);

    // Inverted data reset, ACIN source, AD_DATA multiplier source.
    bus.RST_DATA = 1'b1;
    load_cfg(1'b1, 1'b1, 3'd3, 3'd1, 1'b1);
    bus.RST_DATA = 1'b0; bus.ACIN = 30'h1555; bus.AD_DATA = 27'h123;
    step();
    chk("rdat_x", 32'(bus.X_MUX), 32'h0);
    chk("rdat_acout", 32'(bus.ACOUT), 32'h0);
    chk("rdat_cfg_kept", 32'(cfg_out), 32'h1);
    chk("amult_ad_data", 32'(bus.A_MULT), 32'h123);
    bus.RST_DATA = 1'b1; step();
    chk("acin_s1", 32'(bus.ACOUT), 32'h1555);

    // Bypass with ACIN source.
    load_cfg(1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    bus.RST_DATA = 1'b0; bus.ACIN = 30'h3FFF_FFFF; settle();
    chk("bypass_x", 32'(bus.X_MUX), 32'h3FFF_FFFF);
    chk("bypass_pv", 32'(bus.PIPE_VALID), 32'h1);
    bus.ACIN = 30'h0ABC; settle();
    chk("bypass_x2", 32'(bus.X_MUX), 32'h0ABC);

    // rst wins over a concurrent configuration shift.
    load_cfg(1'b1, 1'b1, 3'd7, 3'd7, 1'b1);
    bus.RST_DATA = 1'b1;
    rst = 1'b1; cfg_en = 1'b1; cfg_in = 1'b1; step();
    rst = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0;
    bus.A = 30'h7; bus.INMODE_EN = 1'b1; bus.MULT_TAP = 3'd0; bus.RST_DATA = 1'b0;
    settle();
    chk("rstcfg_cfg_out", 32'(cfg_out), 32'h0);
    chk("rstcfg_amult", 32'(bus.A_MULT), 32'h7);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      rst          = ($urandom_range(0, 59) == 0);
      cfg_en       = ($urandom_range(0, 11) == 0);
      cfg_in       = 1'($urandom);
      bus.A        = 30'($urandom);
      bus.ACIN     = 30'($urandom);
      bus.AD_DATA  = 27'($urandom);
      bus.CE       = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111;
      bus.RST_DATA = m_cfg[CH-1] ^ ($urandom_range(0, 19) == 0);
      bus.MULT_TAP = 3'($urandom);
      bus.INMODE_EN = 1'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
